// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 4-bit LCD read/write paths:
// op codes, read-controller state encoding and default bus timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        OP_RD_STATUS = 2'b00,
        OP_RD_DATA   = 2'b01,
        OP_WAIT_NB   = 2'b10,
        OP_RSVD      = 2'b11
    } lcd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_EH1   = 3'd2,
        ST_EL1   = 3'd3,
        ST_EH2   = 3'd4,
        ST_EL2   = 3'd5,
        ST_FIN   = 3'd6
    } lcd_rd_state_e;

    // Cycle counts at 50 MHz, shared with the display writer.
    localparam int LCD_T_AS      = 2;
    localparam int LCD_T_EH      = 12;
    localparam int LCD_T_EL      = 12;
    localparam int LCD_MAX_POLLS = 1000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Loadable down-counter with terminal-count flag; one instance times
// every SETUP / E-high / E-low phase of the read cycle.
module lcd_phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/lcd_read_ctrl.sv
// HD44780 4-bit read controller: status/data byte reads and a
// busy-flag poll with timeout, sharing the LCD pins via an external mux.
//
// state | meaning
// IDLE  | ready for a request, bus released (rw = 0)
// SETUP | RS/RW driven, E low, address setup time
// EH1   | E high, high nibble sampled on last cycle
// EL1   | E low between nibbles
// EH2   | E high, low nibble sampled on last cycle
// EL2   | E low, decide finish or re-poll
// FIN   | done pulse, results published
module lcd_read_ctrl
    import lcd_pkg::*;
#(
    parameter int T_AS      = LCD_T_AS,
    parameter int T_EH      = LCD_T_EH,
    parameter int T_EL      = LCD_T_EL,
    parameter int MAX_POLLS = LCD_MAX_POLLS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] op,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       busy_flag,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [3:0] lcd_d_i,
    output logic       lcd_d_oe
);

    localparam int TW = $clog2(max3(T_AS, T_EH, T_EL) + 1);
    localparam int PW = (MAX_POLLS > 1) ? $clog2(MAX_POLLS) : 1;

    localparam logic [TW-1:0] LD_AS = TW'(T_AS - 1);
    localparam logic [TW-1:0] LD_EH = TW'(T_EH - 1);
    localparam logic [TW-1:0] LD_EL = TW'(T_EL - 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

    lcd_rd_state_e state, state_nx;
    logic [1:0]    op_q;
    logic [7:0]    shift_q;
    logic [PW-1:0] poll_cnt;
    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tc;
    logic          is_wait;
    logic          go_poll;
    logic          go_fin;

    lcd_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tc)
    );

    assign is_wait = (op_q == OP_WAIT_NB);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_val  = LD_AS;
        go_poll  = 1'b0;
        go_fin   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nx = ST_SETUP;
                    tmr_load = 1'b1;
                    tmr_val  = LD_AS;
                end
            end
            ST_SETUP: begin
                if (tc) begin
                    state_nx = ST_EH1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EH;
                end
            end
            ST_EH1: begin
                if (tc) begin
                    state_nx = ST_EL1;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EL;
                end
            end
            ST_EL1: begin
                if (tc) begin
                    state_nx = ST_EH2;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EH;
                end
            end
            ST_EH2: begin
                if (tc) begin
                    state_nx = ST_EL2;
                    tmr_load = 1'b1;
                    tmr_val  = LD_EL;
                end
            end
            ST_EL2: begin
                if (tc) begin
                    // RS/RW stay put across polls, so a re-read skips SETUP.
                    if (is_wait && shift_q[7] && (poll_cnt != POLL_LAST)) begin
                        go_poll  = 1'b1;
                        state_nx = ST_EH1;
                        tmr_load = 1'b1;
                        tmr_val  = LD_EH;
                    end else begin
                        go_fin   = 1'b1;
                        state_nx = ST_FIN;
                    end
                end
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q      <= OP_RD_STATUS;
            shift_q   <= 8'h00;
            poll_cnt  <= '0;
            rdata     <= 8'h00;
            busy_flag <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            if (state == ST_IDLE && req) begin
                op_q     <= op;
                poll_cnt <= '0;
            end
            if (state == ST_EH1 && tc) begin
                shift_q[7:4] <= lcd_d_i;
            end
            if (state == ST_EH2 && tc) begin
                shift_q[3:0] <= lcd_d_i;
            end
            if (go_poll) begin
                poll_cnt <= poll_cnt + PW'(1);
            end
            // Results are published on entry to FIN so they line up with done.
            if (go_fin) begin
                rdata   <= shift_q;
                timeout <= is_wait && shift_q[7];
                if (op_q != OP_RD_DATA) begin
                    busy_flag <= shift_q[7];
                end
            end
        end
    end

    assign ready    = (state == ST_IDLE);
    assign done     = (state == ST_FIN);
    assign lcd_e    = (state == ST_EH1) || (state == ST_EH2);
    assign lcd_rw   = (state == ST_SETUP) || (state == ST_EH1) || (state == ST_EL1) ||
                      (state == ST_EH2) || (state == ST_EL2);
    assign lcd_rs   = lcd_rw && (op_q == OP_RD_DATA);
    assign lcd_d_oe = 1'b0;

endmodule

// File: tb/tb_lcd_read_ctrl.sv
// Directed bench for lcd_read_ctrl with an LCD nibble model and a
// scoreboard of expected read results.
module tb_lcd_read_ctrl;
    import lcd_pkg::*;

    localparam int T_AS = 2;
    localparam int T_EH = 12;
    localparam int T_EL = 12;
    localparam int LAT  = T_AS + 2 * (T_EH + T_EL) + 1;
    localparam int POLL = 2 * (T_EH + T_EL);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req, req4;
    logic [1:0] op, op4;
    logic       ready, done, busy_flag, timeout, lcd_rs, lcd_rw, lcd_e, lcd_d_oe;
    logic [7:0] rdata;
    logic [3:0] lcd_d_i = 4'h0;
    logic       ready4, done4, bf4, to4, rs4, rw4, e4, oe4;
    logic [7:0] rdata4;
    logic [3:0] d4 = 4'h8;

    always #10 clk = ~clk;

    lcd_read_ctrl dut (
        .clk(clk), .reset(reset), .req(req), .op(op), .ready(ready), .done(done),
        .rdata(rdata), .busy_flag(busy_flag), .timeout(timeout), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d_i(lcd_d_i), .lcd_d_oe(lcd_d_oe)
    );

    lcd_read_ctrl #(.MAX_POLLS(4)) dut4 (
        .clk(clk), .reset(reset), .req(req4), .op(op4), .ready(ready4), .done(done4),
        .rdata(rdata4), .busy_flag(bf4), .timeout(to4), .lcd_rs(rs4),
        .lcd_rw(rw4), .lcd_e(e4), .lcd_d_i(d4), .lcd_d_oe(oe4)
    );

    typedef struct {
        logic [7:0] rdata;
        logic       bf;
        logic       to;
        int         lat;
    } exp_t;

    exp_t       exp_q[$];
    int         acc_q[$];
    logic [3:0] nib_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         e_rises = 0;
    int         e4_rises = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        assert (got === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // LCD model: present the next queued nibble on each E rise.
    initial forever begin
        @(posedge lcd_e);
        e_rises++;
        if (nib_q.size() > 0) lcd_d_i = nib_q.pop_front();
        else lcd_d_i = 4'h0;
    end

    initial forever begin
        @(posedge e4);
        e4_rises++;
    end

    // Scoreboard and E-timing monitor, sampled mid-low-phase.
    initial begin
        exp_t m_e;
        int   m_a;
        int   e_hi;
        int   e_lo;
        logic e_prev;
        e_hi = 0;
        e_lo = 100;
        e_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                e_hi = 0;
                e_lo = 100;
                e_prev = 1'b0;
            end else begin
                if (req && ready) acc_q.push_back(cyc);
                if (done) begin
                    done_cnt++;
                    if (exp_q.size() == 0 || acc_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        m_e = exp_q.pop_front();
                        m_a = acc_q.pop_front();
                        chk("sb_rdata", rdata, m_e.rdata);
                        chk("sb_busy_flag", busy_flag, m_e.bf);
                        chk("sb_timeout", timeout, m_e.to);
                        chk("sb_latency", cyc - m_a, m_e.lat);
                    end
                end
                if (lcd_e) begin
                    if (!e_prev) begin
                        chk("e_low_gap_ok", (e_lo >= T_EL) ? 1 : 0, 1);
                        e_lo = 0;
                    end
                    e_hi++;
                end else begin
                    if (e_prev) begin
                        chk("e_high_width", e_hi, T_EH);
                        e_hi = 0;
                    end
                    e_lo++;
                end
                e_prev = lcd_e;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic run_op(input logic [1:0] o, input int npolls, input logic [7:0] xd,
                          input logic xbf, input logic xto, input logic xrs);
        int r0;
        int n;
        bit rw_ok;
        bit rs_ok;
        r0 = e_rises;
        n = 0;
        rw_ok = 1'b1;
        rs_ok = 1'b1;
        op = o;
        req = 1'b1;
        exp_q.push_back('{rdata: xd, bf: xbf, to: xto, lat: LAT + npolls * POLL});
        @(negedge clk);
        req = 1'b0;
        chk("ready_low_in_op", ready, 0);
        while (!done && n < 3000) begin
            if (lcd_rw !== 1'b1) rw_ok = 1'b0;
            if (lcd_rs !== xrs) rs_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        chk("rw_held_in_op", rw_ok, 1);
        chk("rs_held_in_op", rs_ok, 1);
        chk("rw_at_fin", lcd_rw, 0);
        chk("rs_at_fin", lcd_rs, 0);
        chk("e_pulses", e_rises - r0, 2 * (npolls + 1));
        @(negedge clk);
        chk("ready_after_op", ready, 1);
    endtask

    initial begin
        int n;
        int d0;
        req = 1'b0;
        op = 2'b00;
        req4 = 1'b0;
        op4 = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_busy_flag", busy_flag, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_e", lcd_e, 0);
        chk("rst_rw", lcd_rw, 0);
        chk("rst_rs", lcd_rs, 0);
        chk("d_oe", lcd_d_oe, 0);
        reset = 1'b0;
        @(negedge clk);

        // status read 0x35, then 0xA5 (BF set), then a data read keeps BF
        nib_q = '{4'h3, 4'h5};
        run_op(OP_RD_STATUS, 0, 8'h35, 1'b0, 1'b0, 1'b0);
        nib_q = '{4'hA, 4'h5};
        run_op(OP_RD_STATUS, 0, 8'hA5, 1'b1, 1'b0, 1'b0);
        nib_q = '{4'h4, 4'h1};
        run_op(OP_RD_DATA, 0, 8'h41, 1'b1, 1'b0, 1'b1);

        // busy for three reads, then clear
        nib_q = '{4'h8, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h7};
        run_op(OP_WAIT_NB, 3, 8'h07, 1'b0, 1'b0, 1'b0);

        // reserved op behaves as a status read
        nib_q = '{4'hC, 4'h2};
        run_op(OP_RSVD, 0, 8'hC2, 1'b1, 1'b0, 1'b0);

        // timeout instance: BF stuck at 1, four polls allowed
        op4 = OP_WAIT_NB;
        req4 = 1'b1;
        @(negedge clk);
        req4 = 1'b0;
        n = 1;
        while (!done4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("to4_done_latency", n, LAT + 3 * POLL);
        chk("to4_reads", e4_rises, 8);
        chk("to4_rdata", rdata4, 8'h88);
        chk("to4_busy_flag", bf4, 1);
        chk("to4_timeout", to4, 1);

        // request pulse during EH1 must be ignored
        d0 = done_cnt;
        nib_q = '{4'h6, 4'h9};
        op = OP_RD_STATUS;
        req = 1'b1;
        exp_q.push_back('{rdata: 8'h69, bf: 1'b0, to: 1'b0, lat: LAT});
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        chk("e_high_in_eh1", lcd_e, 1);
        op = OP_RD_DATA;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (LAT + 60) @(negedge clk);
        chk("pulse_one_done", done_cnt - d0, 1);
        chk("pulse_sb_empty", exp_q.size(), 0);

        // req held high: accepts at 0, 52, 104
        d0 = done_cnt;
        nib_q = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2};
        for (int i = 0; i < 3; i++)
            exp_q.push_back('{rdata: 8'h12, bf: 1'b0, to: 1'b0, lat: LAT});
        op = OP_RD_STATUS;
        req = 1'b1;
        repeat (105) @(negedge clk);
        req = 1'b0;
        repeat (LAT + 60) @(negedge clk);
        chk("held_done_count", done_cnt - d0, 3);
        chk("held_sb_empty", exp_q.size(), 0);

        // reset during EH2
        nib_q = '{4'h3, 4'h5};
        op = OP_RD_STATUS;
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (29) @(negedge clk);
        chk("e_high_in_eh2", lcd_e, 1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        chk("rst_mid_e", lcd_e, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_rdata", rdata, 8'h00);
        acc_q.delete();
        nib_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_no_done", done_cnt - d0, 0);
        nib_q = '{4'h3, 4'h5};
        run_op(OP_RD_STATUS, 0, 8'h35, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
